// File: rtl/done_flag_collector.sv
// Sticky per-lane done collector feeding and_tree_seq; issues a barrier release and drains stale tree results.
// Optional watchdog compiled in with `define DONE_COLLECTOR_TIMEOUT_EN.
module done_flag_collector #(
  parameter int NUM_INPUT_DATA = 8,
  parameter int TREE_LATENCY   = 3,
  parameter int EPOCH_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_en,
  input  logic [NUM_INPUT_DATA-1:0] i_done,
  output logic [NUM_INPUT_DATA-1:0] o_valid,
  output logic [NUM_INPUT_DATA-1:0] o_data_bus,
  input  logic                      i_tree_valid,
  input  logic                      i_tree_result,
  output logic                      o_release,
  output logic [EPOCH_WIDTH-1:0]    o_epoch,
  output logic                      o_busy,
  output logic                      o_timeout
);

  localparam int DW = (TREE_LATENCY > 1) ? $clog2(TREE_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_RELEASE,
    S_DRAIN
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [NUM_INPUT_DATA-1:0] r_flags;
  logic [NUM_INPUT_DATA-1:0] w_flags_nxt;
  logic                      r_valid;
  logic [EPOCH_WIDTH-1:0]    r_epoch;
  logic [DW-1:0]             r_drain_cnt;
  logic [DW-1:0]             w_drain_cnt_nxt;
  logic                      w_go;
  logic                      w_clear;
  logic                      w_timeout;

  assign w_go = i_en & (r_state == S_COLLECT) & i_tree_valid & i_tree_result;

`ifdef DONE_COLLECTOR_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] r_wd_cnt;
  logic          w_wd_hit;

  // Counts enabled COLLECT cycles while any flag is set; a same-cycle release suppresses the timeout.
  assign w_wd_hit  = i_en & (r_state == S_COLLECT) & (r_wd_cnt == WW'(TIMEOUT_CYCLES));
  assign w_timeout = w_wd_hit & ~w_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (i_en) begin
      if ((r_state != S_COLLECT) || w_go || w_timeout) begin
        r_wd_cnt <= '0;
      end else if (|r_flags) begin
        r_wd_cnt <= r_wd_cnt + WW'(1);
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_clear         = 1'b0;
    if (i_en) begin
      case (r_state)
        S_COLLECT: begin
          if (w_go) begin
            w_state_nxt = S_RELEASE;
          end else if (w_timeout) begin
            w_clear         = 1'b1;
            w_state_nxt     = S_DRAIN;
            w_drain_cnt_nxt = '0;
          end
        end
        S_RELEASE: begin
          w_clear         = 1'b1;
          w_state_nxt     = S_DRAIN;
          w_drain_cnt_nxt = '0;
        end
        S_DRAIN: begin
          if (r_drain_cnt == DW'(TREE_LATENCY - 1)) begin
            w_state_nxt = S_COLLECT;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt + DW'(1);
          end
        end
        default: w_state_nxt = S_COLLECT;
      endcase
    end
    // New done pulses win over the clear so they count toward the next epoch.
    w_flags_nxt = (w_clear ? '0 : r_flags) | (i_en ? i_done : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_COLLECT;
      r_flags     <= '0;
      r_valid     <= 1'b0;
      r_epoch     <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flags     <= w_flags_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      // Registered so the valid strobe lines up with the registered flag bus.
      r_valid     <= i_en & (w_state_nxt == S_COLLECT);
      if (i_en && (r_state == S_RELEASE)) begin
        r_epoch <= r_epoch + EPOCH_WIDTH'(1);
      end
    end
  end

  assign o_valid    = {NUM_INPUT_DATA{r_valid}};
  assign o_data_bus = r_flags;
  assign o_release  = i_en & (r_state == S_RELEASE);
  assign o_epoch    = r_epoch;
  assign o_busy     = (|r_flags) | (r_state != S_COLLECT);
  assign o_timeout  = w_timeout;

endmodule
